dispatch_stage: RTL and testbench

- Sits between rename and the reservation stations. It is the producer side of the RS dispatch handshake: it drives rs_base / option_code / wr_valid and consumes wr_ready.
- Buffers one renamed group per cycle and owns the physical-register busy table.
- Computes the initial psrc0_ready / psrc1_ready bits, including same-cycle writeback bypass, so that no wakeup is lost between rename and RS entry.
- Lane i feeds RS bank i (DISPATCH_WIDTH == RS BANK_NUM).

---
 rtl/dispatch_stage_pkg.sv | 54 +++++
 rtl/dispatch_stage_busy_table.sv | 33 +++
 rtl/dispatch_stage.sv | 65 ++++++
 tb/tb_dispatch_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_stage_pkg.sv
// dispatch_stage_pkg: shared configuration, dispatch/RS entry types and the RS base builder.
package dispatch_stage_pkg;
  localparam int CFG_DISPATCH_WIDTH = 2;
  localparam int CFG_PHY_REG_NUM = 64;
  localparam int CFG_WB_WIDTH = 2;
  localparam int PREG_W = $clog2(CFG_PHY_REG_NUM);
  localparam int ROB_W = 5;
  typedef logic [PREG_W-1:0] preg_t;
  typedef struct packed {
    logic [2:0] fu_type;
    logic [4:0] op;
  } option_code_t;
  typedef struct packed {
    preg_t psrc0;
    logic psrc0_valid;
    preg_t psrc1;
    logic psrc1_valid;
    preg_t pdest;
    logic pdest_valid;
    logic [ROB_W-1:0] rob_idx;
    logic position_bit;
    option_code_t oc;
  } dispatch_inst_t;
  typedef struct packed {
    logic valid;
    logic issued;
    preg_t psrc0;
    logic psrc0_valid;
    logic psrc0_ready;
    preg_t psrc1;
    logic psrc1_valid;
    logic psrc1_ready;
    preg_t pdest;
    logic pdest_valid;
    logic [ROB_W-1:0] rob_idx;
    logic position_bit;
  } rs_base_t;
  function automatic rs_base_t build_rs_base(dispatch_inst_t inst, logic r0, logic r1);
    rs_base_t b;
    b.valid = 1'b1;
    b.issued = 1'b0;
    b.psrc0 = inst.psrc0;
    b.psrc0_valid = inst.psrc0_valid;
    b.psrc0_ready = r0;
    b.psrc1 = inst.psrc1;
    b.psrc1_valid = inst.psrc1_valid;
    b.psrc1_ready = r1;
    b.pdest = inst.pdest;
    b.pdest_valid = inst.pdest_valid;
    b.rob_idx = inst.rob_idx;
    b.position_bit = inst.position_bit;
    return b;
  endfunction
endpackage

// File: rtl/dispatch_stage_busy_table.sv
// dispatch_stage_busy_table: physical-register busy bits with set/clear ports and wb-bypassed reads.
module dispatch_stage_busy_table
  import dispatch_stage_pkg::*;
#(
  parameter int N = 2,
  parameter int RD = 4,
  parameter int WB = 2,
  parameter int PHY = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic [N-1:0] set_en,
  input  preg_t [N-1:0] set_preg,
  input  logic [WB-1:0] wb,
  input  preg_t [WB-1:0] wb_preg,
  input  preg_t [RD-1:0] rd_preg,
  output logic [RD-1:0] rd_ready
);
  logic [PHY-1:0] busy, set_mask, clr_mask;
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < N; i++) if (set_en[i] && set_preg[i] != '0) set_mask[set_preg[i]] = 1'b1;
    for (int k = 0; k < WB; k++) if (wb[k]) clr_mask[wb_preg[k]] = 1'b1;
    for (int r = 0; r < RD; r++)
      rd_ready[r] = rd_preg[r] == '0 || !busy[rd_preg[r]] || clr_mask[rd_preg[r]];
  end
  // set applied after clear so a same-cycle re-allocation stays busy
  always_ff @(posedge clk)
    if (rst || flush) busy <= '0;
    else busy <= (busy & ~clr_mask) | set_mask;
endmodule

// File: rtl/dispatch_stage.sv
// dispatch_stage: buffers one renamed group, tracks preg busy state and drives the RS write handshake.
module dispatch_stage
  import dispatch_stage_pkg::*;
#(
  parameter int DISPATCH_WIDTH = CFG_DISPATCH_WIDTH,
  parameter int PHY_REG_NUM = CFG_PHY_REG_NUM,
  parameter int WB_WIDTH = CFG_WB_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic [DISPATCH_WIDTH-1:0] rename_valid_i,
  input  dispatch_inst_t [DISPATCH_WIDTH-1:0] rename_inst_i,
  output logic rename_ready_o,
  input  logic [WB_WIDTH-1:0] wb_i,
  input  preg_t [WB_WIDTH-1:0] wb_pdest_i,
  output rs_base_t [DISPATCH_WIDTH-1:0] rs_base_o,
  output option_code_t [DISPATCH_WIDTH-1:0] option_code_o,
  output logic [DISPATCH_WIDTH-1:0] wr_valid_o,
  input  logic [DISPATCH_WIDTH-1:0] wr_ready_i
);
  logic [DISPATCH_WIDTH-1:0] pending, done, set_en;
  dispatch_inst_t [DISPATCH_WIDTH-1:0] inst_q;
  preg_t [DISPATCH_WIDTH-1:0] set_preg;
  preg_t [2*DISPATCH_WIDTH-1:0] rd_preg;
  logic [2*DISPATCH_WIDTH-1:0] rd_ready;
  logic accept;
  assign wr_valid_o = rst ? '0 : pending & {DISPATCH_WIDTH{~flush_i}};
  assign done = ~pending | (wr_valid_o & wr_ready_i);
  assign rename_ready_o = &done & ~flush_i & ~rst;
  assign accept = rename_ready_o & |rename_valid_i;
  always_ff @(posedge clk)
    if (rst || flush_i) pending <= '0;
    else if (accept) begin
      pending <= rename_valid_i;
      inst_q <= rename_inst_i;
    end else pending <= pending & ~done;
  // ready bits are rebuilt every cycle so a stalled lane keeps observing wakeups
  always_comb
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      set_en[i] = accept & rename_valid_i[i] & rename_inst_i[i].pdest_valid;
      set_preg[i] = rename_inst_i[i].pdest;
      rd_preg[2*i] = inst_q[i].psrc0;
      rd_preg[2*i+1] = inst_q[i].psrc1;
      rs_base_o[i] = rst ? '0 : build_rs_base(inst_q[i], ~inst_q[i].psrc0_valid | rd_ready[2*i],
                                              ~inst_q[i].psrc1_valid | rd_ready[2*i+1]);
      option_code_o[i] = rst ? '0 : inst_q[i].oc;
    end
  dispatch_stage_busy_table #(
    .N(DISPATCH_WIDTH),
    .RD(2 * DISPATCH_WIDTH),
    .WB(WB_WIDTH),
    .PHY(PHY_REG_NUM)
  ) u_busy (
    .clk(clk),
    .rst(rst),
    .flush(flush_i),
    .set_en(set_en),
    .set_preg(set_preg),
    .wb(wb_i),
    .wb_preg(wb_pdest_i),
    .rd_preg(rd_preg),
    .rd_ready(rd_ready)
  );
endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed scenarios plus random traffic checked against a behavioural model.
module tb_dispatch_stage;
  import dispatch_stage_pkg::*;
  localparam int W = CFG_DISPATCH_WIDTH;
  localparam int WB = CFG_WB_WIDTH;
  logic clk = 0, rst = 1, flush_i = 0, rename_ready_o;
  logic [W-1:0] rename_valid_i = '0, wr_valid_o, wr_ready_i = '1;
  dispatch_inst_t [W-1:0] rename_inst_i = '0;
  logic [WB-1:0] wb_i = '0;
  preg_t [WB-1:0] wb_pdest_i = '0;
  rs_base_t [W-1:0] rs_base_o;
  option_code_t [W-1:0] option_code_o;
  int checks = 0, errors = 0;
  logic [W-1:0] m_pend = '0;
  dispatch_inst_t m_inst [W];
  logic [CFG_PHY_REG_NUM-1:0] m_busy = '0;
  always #5 clk = ~clk;
  dispatch_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .rename_valid_i(rename_valid_i),
    .rename_inst_i(rename_inst_i), .rename_ready_o(rename_ready_o), .wb_i(wb_i),
    .wb_pdest_i(wb_pdest_i), .rs_base_o(rs_base_o), .option_code_o(option_code_o),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i)
  );
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  function automatic logic src_ready(preg_t p, logic v);
    logic r;
    r = !v || p == 0 || !m_busy[p];
    for (int k = 0; k < WB; k++) if (wb_i[k] && wb_pdest_i[k] == p) r = 1'b1;
    return r;
  endfunction
  function automatic logic [W-1:0] exp_wv();
    return (rst || flush_i) ? '0 : m_pend;
  endfunction
  function automatic logic [W-1:0] exp_done();
    return ~m_pend | (exp_wv() & wr_ready_i);
  endfunction
  function automatic logic exp_rr();
    return &exp_done() && !flush_i && !rst;
  endfunction
  always @(negedge clk) begin
    rs_base_t e;
    chk("rename_ready", 64'(rename_ready_o), 64'(exp_rr()));
    chk("wr_valid", 64'(wr_valid_o), 64'(exp_wv()));
    for (int i = 0; i < W; i++)
      if (rst) begin
        chk("rs_base_in_reset", 64'(rs_base_o[i]), 64'(0));
        chk("option_code_in_reset", 64'(option_code_o[i]), 64'(0));
      end else if (m_pend[i] && !flush_i) begin
        e = '0;
        e.valid = 1'b1;
        e.psrc0 = m_inst[i].psrc0;
        e.psrc0_valid = m_inst[i].psrc0_valid;
        e.psrc0_ready = src_ready(m_inst[i].psrc0, m_inst[i].psrc0_valid);
        e.psrc1 = m_inst[i].psrc1;
        e.psrc1_valid = m_inst[i].psrc1_valid;
        e.psrc1_ready = src_ready(m_inst[i].psrc1, m_inst[i].psrc1_valid);
        e.pdest = m_inst[i].pdest;
        e.pdest_valid = m_inst[i].pdest_valid;
        e.rob_idx = m_inst[i].rob_idx;
        e.position_bit = m_inst[i].position_bit;
        chk("rs_base", 64'(rs_base_o[i]), 64'(e));
        chk("option_code", 64'(option_code_o[i]), 64'(m_inst[i].oc));
      end
  end
  always @(posedge clk) begin
    logic [CFG_PHY_REG_NUM-1:0] nb;
    logic [W-1:0] dn;
    nb = m_busy;
    dn = exp_done();
    if (rst || flush_i) begin
      m_pend <= '0;
      m_busy <= '0;
    end else begin
      for (int k = 0; k < WB; k++) if (wb_i[k]) nb[wb_pdest_i[k]] = 1'b0;
      if (exp_rr() && |rename_valid_i) begin
        m_pend <= rename_valid_i;
        for (int i = 0; i < W; i++) begin
          m_inst[i] <= rename_inst_i[i];
          if (rename_valid_i[i] && rename_inst_i[i].pdest_valid && rename_inst_i[i].pdest != 0)
            nb[rename_inst_i[i].pdest] = 1'b1;
        end
      end else m_pend <= m_pend & ~dn;
      m_busy <= nb;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rename_valid_i = '0;
    rename_inst_i = '0;
    wb_i = '0;
    flush_i = 0;
  endtask
  function automatic dispatch_inst_t mk(preg_t s0, logic v0, preg_t s1, logic v1, preg_t d, logic dv);
    dispatch_inst_t x;
    x = '0;
    x.psrc0 = s0;
    x.psrc0_valid = v0;
    x.psrc1 = s1;
    x.psrc1_valid = v1;
    x.pdest = d;
    x.pdest_valid = dv;
    x.rob_idx = 5'($urandom);
    x.position_bit = 1'($urandom);
    x.oc = 8'($urandom);
    return x;
  endfunction
  initial begin
    repeat (2) tick();
    @(negedge clk);
    chk("reset_rename_ready", 64'(rename_ready_o), 64'(0));
    chk("reset_wr_valid", 64'(wr_valid_o), 64'(0));
    chk("reset_rs_base", 64'(rs_base_o[0]), 64'(0));
    tick();
    rst = 0;
    rename_valid_i = 2'b11;
    rename_inst_i[0] = mk(5, 1, 0, 0, 7, 1);
    rename_inst_i[1] = mk(7, 1, 0, 0, 8, 1);
    @(negedge clk);
    chk("first_accept_ready", 64'(rename_ready_o), 64'(1));
    tick();
    idle();
    wr_ready_i = 2'b01;
    @(negedge clk);
    chk("group_wr_valid", 64'(wr_valid_o), 64'(2'b11));
    chk("lane0_psrc0_ready", 64'(rs_base_o[0].psrc0_ready), 64'(1));
    chk("lane1_psrc0_busy", 64'(rs_base_o[1].psrc0_ready), 64'(0));
    chk("stall_rename_ready", 64'(rename_ready_o), 64'(0));
    chk("model_busy7", 64'(m_busy[7]), 64'(1));
    tick();
    wb_i = 2'b01;
    wb_pdest_i[0] = 7;
    wr_ready_i = 2'b00;
    @(negedge clk);
    chk("stalled_wr_valid", 64'(wr_valid_o), 64'(2'b10));
    chk("stalled_wakeup_bypass", 64'(rs_base_o[1].psrc0_ready), 64'(1));
    chk("stalled_rename_ready", 64'(rename_ready_o), 64'(0));
    tick();
    wb_i = '0;
    wr_ready_i = 2'b10;
    @(negedge clk);
    chk("stalled_wakeup_held", 64'(rs_base_o[1].psrc0_ready), 64'(1));
    chk("drain_rename_ready", 64'(rename_ready_o), 64'(1));
    tick();
    wr_ready_i = 2'b11;
    rename_valid_i = 2'b01;
    rename_inst_i[0] = mk(0, 0, 0, 0, 9, 1);
    tick();
    idle();
    rename_valid_i = 2'b01;
    rename_inst_i[0] = mk(0, 0, 9, 1, 0, 0);
    @(negedge clk);
    chk("b2b_rename_ready", 64'(rename_ready_o), 64'(1));
    tick();
    idle();
    wr_ready_i = 2'b00;
    wb_i = 2'b01;
    wb_pdest_i[0] = 9;
    @(negedge clk);
    chk("bypass_wr_valid", 64'(wr_valid_o), 64'(2'b01));
    chk("bypass_psrc1_ready", 64'(rs_base_o[0].psrc1_ready), 64'(1));
    tick();
    wb_i = '0;
    @(negedge clk);
    chk("cleared_psrc1_ready", 64'(rs_base_o[0].psrc1_ready), 64'(1));
    chk("model_busy9", 64'(m_busy[9]), 64'(0));
    wr_ready_i = 2'b11;
    tick();
    rename_valid_i = 2'b01;
    rename_inst_i[0] = mk(0, 0, 0, 0, 12, 1);
    wb_i = 2'b01;
    wb_pdest_i[0] = 12;
    tick();
    idle();
    rename_valid_i = 2'b01;
    rename_inst_i[0] = mk(12, 1, 0, 0, 0, 0);
    tick();
    idle();
    wr_ready_i = 2'b00;
    @(negedge clk);
    chk("set_wins_psrc0_ready", 64'(rs_base_o[0].psrc0_ready), 64'(0));
    chk("set_wins_model", 64'(m_busy[12]), 64'(1));
    wr_ready_i = 2'b11;
    tick();
    rename_valid_i = 2'b01;
    rename_inst_i[0] = mk(0, 1, 0, 0, 0, 1);
    tick();
    idle();
    @(negedge clk);
    chk("preg0_ready", 64'(rs_base_o[0].psrc0_ready), 64'(1));
    chk("model_busy0", 64'(m_busy[0]), 64'(0));
    tick();
    rename_valid_i = 2'b01;
    rename_inst_i[0] = mk(0, 0, 0, 0, 3, 1);
    tick();
    idle();
    wr_ready_i = 2'b00;
    flush_i = 1;
    @(negedge clk);
    chk("flush_wr_valid", 64'(wr_valid_o), 64'(0));
    chk("flush_rename_ready", 64'(rename_ready_o), 64'(0));
    tick();
    flush_i = 0;
    rename_valid_i = 2'b01;
    rename_inst_i[0] = mk(3, 1, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_flush_wr_valid", 64'(wr_valid_o), 64'(0));
    chk("post_flush_rename_ready", 64'(rename_ready_o), 64'(1));
    tick();
    idle();
    @(negedge clk);
    chk("post_flush_busy_clear", 64'(rs_base_o[0].psrc0_ready), 64'(1));
    chk("post_flush_new_wr_valid", 64'(wr_valid_o), 64'(2'b01));
    wr_ready_i = 2'b11;
    tick();
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 99) == 0;
      flush_i = $urandom_range(0, 39) == 0;
      rename_valid_i = 2'($urandom);
      for (int i = 0; i < W; i++)
        rename_inst_i[i] = mk(4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                              4'($urandom), 1'($urandom));
      for (int i = 0; i < W; i++) wr_ready_i[i] = $urandom_range(0, 3) != 0;
      for (int k = 0; k < WB; k++) begin
        wb_i[k] = $urandom_range(0, 2) == 0;
        wb_pdest_i[k] = 4'($urandom);
      end
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
